// File: rtl/alu_driver_if.sv
// Bundles the command, ALU and response channels of alu_driver.
// The master modport belongs to the environment; slave is the driver itself.
interface alu_driver_if #(
  parameter int ALU_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_opcode;
  logic [ALU_WIDTH-1:0] cmd_a;
  logic [ALU_WIDTH-1:0] cmd_b;
  logic                 cmd_acc;
  logic                 cmd_clr;

  logic [ALU_WIDTH-1:0] alu_op1;
  logic [ALU_WIDTH-1:0] alu_op2;
  logic [1:0]           alu_opcode;
  logic [ALU_WIDTH-1:0] alu_result;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ALU_WIDTH-1:0] rsp_data;
  logic                 rsp_zero;
  logic [CNT_WIDTH-1:0] op_cnt;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_acc, cmd_clr,
    output alu_result, rsp_ready,
    input  cmd_ready, alu_op1, alu_op2, alu_opcode,
    input  rsp_valid, rsp_data, rsp_zero, op_cnt
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_acc, cmd_clr,
    input  alu_result, rsp_ready,
    output cmd_ready, alu_op1, alu_op2, alu_opcode,
    output rsp_valid, rsp_data, rsp_zero, op_cnt
  );
endinterface

// File: rtl/alu_driver.sv
// Sequential initiator for a combinational ALU: registers operands on command accept,
// captures the ALU result one cycle later and returns it over a valid/ready response.
module alu_driver #(
  parameter int ALU_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ALU_WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [ALU_WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic [1:0]           alu_opcode_q, alu_opcode_d;
  logic [ALU_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ALU_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] op_cnt_q, op_cnt_d;

  logic cmd_ready;
  logic accept;
  logic rsp_fire;

  // A new command may be taken in the same cycle the pending response is consumed.
  assign cmd_ready = ~rst & ((state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready));
  assign accept    = bus.cmd_valid & cmd_ready;
  assign rsp_fire  = (state_q == RESP) & bus.rsp_ready;

  always_comb begin
    state_d      = state_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    alu_opcode_d = alu_opcode_q;
    rsp_data_d   = rsp_data_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_valid_d  = rsp_valid_q;
    acc_d        = acc_q;
    op_cnt_d     = op_cnt_q;

    case (state_q)
      IDLE: begin
        rsp_valid_d = 1'b0;
      end
      EXEC: begin
        rsp_data_d  = bus.alu_result;
        acc_d       = bus.alu_result;
        rsp_zero_d  = (bus.alu_result == '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          op_cnt_d    = op_cnt_q + 1'b1;
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Accumulate mode with clear reads zero rather than the stale accumulator.
    if (accept) begin
      if (bus.cmd_acc) begin
        alu_op1_d = bus.cmd_clr ? '0 : acc_q;
      end else begin
        alu_op1_d = bus.cmd_a;
      end
      alu_op2_d    = bus.cmd_b;
      alu_opcode_d = bus.cmd_opcode;
      if (bus.cmd_clr) begin
        acc_d = '0;
      end
      state_d = EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_opcode_q <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      acc_q        <= '0;
      op_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      alu_opcode_q <= alu_opcode_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
      acc_q        <= acc_d;
      op_cnt_q     <= op_cnt_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.op_cnt     = op_cnt_q;

endmodule
